// File: rtl/moves_pipe.sv
// Buffered move-immediate unit: byte-lane insert into a register value,
// queued in a small result FIFO with forwarding of pending writes.
module moves_pipe #(
  parameter int DATA_W = 16,
  parameter int NREG   = 8,
  parameter int DEPTH  = 2,
  localparam int NLANE  = DATA_W / 8,
  localparam int REG_AW = $clog2(NREG),
  localparam int CNT_W  = $clog2(DEPTH + 1),
  localparam int LANE_W = (NLANE > 1) ? $clog2(NLANE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        op,
  input  logic [REG_AW-1:0] dst,
  input  logic [LANE_W-1:0] lane,
  input  logic [7:0]        imm,
  output logic [REG_AW-1:0] rf_raddr,
  input  logic [DATA_W-1:0] rf_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [REG_AW-1:0] out_dst,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  occupancy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] OP_MOVL  = 2'b00;
  localparam logic [1:0] OP_MOVLZ = 2'b01;
  localparam logic [1:0] OP_MOVLS = 2'b10;
  localparam logic [1:0] OP_MOVH  = 2'b11;

  logic [DATA_W-1:0] data_q [DEPTH];
  logic [REG_AW-1:0] dst_q  [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              push, pop;
  logic [DATA_W-1:0] base;
  logic [DATA_W-1:0] res;
  int                lsel;

  assign rf_raddr  = dst;
  assign out_valid = (cnt_q != '0);
  assign out_dst   = dst_q[rd_ptr_q];
  assign out_data  = data_q[rd_ptr_q];
  assign occupancy = cnt_q;
  assign in_ready  = (cnt_q < CNT_W'(DEPTH)) | (out_valid & out_ready);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  // Walk oldest to youngest so the youngest matching entry wins.
  always_comb begin
    base = rf_rdata;
    for (int k = 0; k < DEPTH; k++) begin
      int idx;
      idx = (int'(rd_ptr_q) + k) % DEPTH;
      if (k < int'(cnt_q) && dst_q[PTR_W'(idx)] == dst)
        base = data_q[PTR_W'(idx)];
    end
  end

  always_comb begin
    lsel = int'(lane) % NLANE;
    if (op == OP_MOVH)
      lsel = (lsel + 1) % NLANE;
  end

  always_comb begin
    res = '0;
    for (int i = 0; i < NLANE; i++) begin
      if (i == lsel) begin
        res[i*8 +: 8] = imm;
      end else begin
        case (op)
          OP_MOVLZ: res[i*8 +: 8] = 8'h00;
          OP_MOVLS: res[i*8 +: 8] = (i > lsel) ? 8'hFF : 8'h00;
          default:  res[i*8 +: 8] = base[i*8 +: 8];
        endcase
      end
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push)
        wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      if (pop)
        rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= '0;
        dst_q[k]  <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      if (push && !flush) begin
        data_q[wr_ptr_q] <= res;
        dst_q[wr_ptr_q]  <= dst;
      end
    end
  end

endmodule

// File: tb/tb_moves_pipe.sv
// Directed bench for moves_pipe: vector table plus FIFO,
// forwarding, flush and reset sequences.
module tb_moves_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [1:0]  op;
  logic [2:0]  dst;
  logic        lane;
  logic [7:0]  imm;
  logic [2:0]  rf_raddr;
  logic [15:0] rf_rdata;
  logic        out_valid, out_ready;
  logic [2:0]  out_dst;
  logic [15:0] out_data;
  logic [1:0]  occupancy;

  logic        v32, rdy32;
  logic [1:0]  op32;
  logic [2:0]  dst32;
  logic [1:0]  lane32;
  logic [7:0]  imm32;
  logic [2:0]  raddr32;
  logic [31:0] rf32;
  logic        ov32, ordy32;
  logic [2:0]  odst32;
  logic [31:0] odata32;
  logic [1:0]  occ32;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  moves_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .dst(dst), .lane(lane), .imm(imm),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_dst(out_dst), .out_data(out_data),
    .occupancy(occupancy)
  );

  moves_pipe #(.DATA_W(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(v32), .in_ready(rdy32),
    .op(op32), .dst(dst32), .lane(lane32), .imm(imm32),
    .rf_raddr(raddr32), .rf_rdata(rf32),
    .out_valid(ov32), .out_ready(ordy32),
    .out_dst(odst32), .out_data(odata32),
    .occupancy(occ32)
  );

  typedef struct {
    logic [1:0]  op;
    logic [2:0]  dst;
    logic        lane;
    logic [7:0]  imm;
    logic [15:0] rf;
    logic [15:0] exp;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] o, input logic [2:0] d,
                       input logic l, input logic [7:0] i,
                       input logic [15:0] rf);
    op = o; dst = d; lane = l; imm = i; rf_rdata = rf;
  endtask

  initial begin
    vt[0] = '{2'b00, 3'd3, 1'b0, 8'h12, 16'hABCD, 16'hAB12};
    vt[1] = '{2'b01, 3'd2, 1'b1, 8'h34, 16'hFFFF, 16'h3400};
    vt[2] = '{2'b10, 3'd1, 1'b0, 8'h80, 16'h0000, 16'hFF80};
    vt[3] = '{2'b10, 3'd4, 1'b1, 8'h80, 16'hFFFF, 16'h8000};
    vt[4] = '{2'b11, 3'd5, 1'b0, 8'h56, 16'hABCD, 16'h56CD};
    vt[5] = '{2'b11, 3'd6, 1'b1, 8'h9A, 16'hABCD, 16'hAB9A};
    vt[6] = '{2'b00, 3'd7, 1'b1, 8'hEE, 16'h1234, 16'hEE34};
    vt[7] = '{2'b01, 3'd0, 1'b0, 8'h5A, 16'h1234, 16'h005A};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(2'b00, 3'd0, 1'b0, 8'h00, 16'h0000);
    v32 = 1'b0; op32 = '0; dst32 = '0; lane32 = '0; imm32 = '0;
    rf32 = '0; ordy32 = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_occupancy", occupancy, 0);
    chk("rst_out_dst", out_dst, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      drive(vt[i].op, vt[i].dst, vt[i].lane, vt[i].imm, vt[i].rf);
      in_valid = 1'b1;
      #1 chk($sformatf("v%0d_raddr", i), rf_raddr, vt[i].dst);
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_dst", i), out_dst, vt[i].dst);
      chk($sformatf("v%0d_data", i), out_data, vt[i].exp);
      @(negedge clk);
      chk($sformatf("v%0d_drain", i), occupancy, 0);
    end

    // forwarding from a queued entry
    out_ready = 1'b0;
    drive(2'b01, 3'd1, 1'b0, 8'h34, 16'hFFFF);
    in_valid = 1'b1;
    @(negedge clk);
    drive(2'b11, 3'd1, 1'b0, 8'h56, 16'hFFFF);
    chk("fw_occ1", occupancy, 1);
    chk("fw_head1", out_data, 16'h0034);
    @(negedge clk);
    in_valid = 1'b0;
    chk("fw_occ2", occupancy, 2);
    chk("fw_head_hold", out_data, 16'h0034);
    out_ready = 1'b1;
    @(negedge clk);
    chk("fw_head2", out_data, 16'h5634);
    chk("fw_occ3", occupancy, 1);
    @(negedge clk);
    chk("fw_empty", occupancy, 0);

    // full FIFO, then push and pop in the same cycle
    out_ready = 1'b0;
    drive(2'b00, 3'd4, 1'b0, 8'h11, 16'h0000);
    in_valid = 1'b1;
    @(negedge clk);
    drive(2'b00, 3'd5, 1'b0, 8'h22, 16'h0000);
    @(negedge clk);
    drive(2'b00, 3'd6, 1'b0, 8'h33, 16'h0000);
    #1;
    chk("full_occ", occupancy, 2);
    chk("full_ready", in_ready, 0);
    @(negedge clk);
    chk("full_hold_occ", occupancy, 2);
    chk("full_hold_head", out_data, 16'h0011);
    out_ready = 1'b1;
    #1 chk("full_ready_comb", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("pp_occ", occupancy, 2);
    chk("pp_dst", out_dst, 5);
    chk("pp_data", out_data, 16'h0022);
    @(negedge clk);
    chk("pp_third", out_data, 16'h0033);
    chk("pp_occ1", occupancy, 1);
    @(negedge clk);
    chk("pp_empty", out_valid, 0);

    // flush beats push and pop
    out_ready = 1'b0;
    drive(2'b00, 3'd1, 1'b0, 8'hA1, 16'h0000);
    in_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("fl_pre_occ", occupancy, 2);
    out_ready = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_occ", occupancy, 0);
    chk("fl_valid", out_valid, 0);
    @(negedge clk);
    chk("fl_dropped", out_valid, 0);

    // 32-bit lanes, sign fill and MOVH wrap
    op32 = 2'b10; dst32 = 3'd1; lane32 = 2'd1; imm32 = 8'h80;
    rf32 = 32'h0000_0000;
    v32 = 1'b1;
    @(negedge clk);
    chk("w32_movls", odata32, 32'hFFFF8000);
    op32 = 2'b11; dst32 = 3'd2; lane32 = 2'd3; imm32 = 8'h9A;
    rf32 = 32'h1122_3344;
    @(negedge clk);
    v32 = 1'b0;
    chk("w32_movh_wrap", odata32, 32'h1122339A);
    chk("w32_dst", odst32, 2);

    // asynchronous reset mid-stream
    out_ready = 1'b0;
    drive(2'b00, 3'd2, 1'b0, 8'h77, 16'h0000);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_pre_occ", occupancy, 1);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_occ", occupancy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    out_ready = 1'b1;
    drive(2'b01, 3'd0, 1'b0, 8'h01, 16'hFFFF);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    chk("ar_post_data", out_data, 16'h0001);
    chk("ar_post_dst", out_dst, 0);
    chk("ar_post_valid", out_valid, 1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
